cpu_run_ctrl: RTL and testbench

- Synthesizable run controller for the pipelined MIPS core; replaces the fixed reset pulse and free-running clock of the old bench.
- Generates a parametrised core reset and a core enable.
- Counts cycles and retired instructions, and detects program end: a halt PC, or a self-loop seen on N consecutive retirements.
- Flags timeout after a cycle budget; supports restart without global reset.
- Sits between the top-level clock/reset and the `mips` core, observing its writeback-stage PC.

---
 rtl/cpu_run_ctrl.sv | 136 +++++++++++++
 tb/tb_cpu_run_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// Run controller for the pipelined MIPS core: sequences core reset/enable,
// counts RUN cycles and retirements, and ends the run on halt or cycle budget.
module cpu_run_ctrl #(
  parameter int unsigned RESET_CYCLES = 3,
  parameter int unsigned MAX_CYCLES   = 10000,
  parameter int unsigned HALT_REPEAT  = 4,
  parameter logic [31:0] HALT_PC      = 32'h0000_3ffc,
  parameter bit          HALT_PC_EN   = 1'b1,
  parameter bit          AUTO_START   = 1'b1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             retire_valid,
  input  logic [31:0]      retire_pc,
  output logic             cpu_reset,
  output logic             cpu_en,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retire_count
);

  localparam int unsigned RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int unsigned SW = $clog2(HALT_REPEAT);
  localparam logic [RW-1:0]    RST_LAST  = RW'(RESET_CYCLES - 1);
  localparam logic [SW-1:0]    SAME_LAST = SW'(HALT_REPEAT - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(MAX_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_HOLD,
    S_RUN,
    S_DONE,
    S_TIMEOUT
  } state_t;

  state_t           state_q, state_d;
  logic [RW-1:0]    rst_cnt_q, rst_cnt_d;
  logic [SW-1:0]    same_q, same_d;
  logic [31:0]      last_pc_q, last_pc_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic [SW-1:0]    same_inc;
  logic             halt;
  logic             cpu_reset_q, cpu_en_q, running_q, done_q, timeout_q;

  assign same_inc = same_q + SW'(1);

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    same_d    = same_q;
    last_pc_d = last_pc_q;
    cyc_d     = cyc_q;
    ret_d     = ret_q;
    halt      = 1'b0;
    case (state_q)
      S_IDLE: ;
      S_RST_HOLD: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d   = S_RUN;
          last_pc_d = '1;
          same_d    = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + RW'(1);
        end
      end
      S_RUN: begin
        if (cyc_q != '1) cyc_d = cyc_q + CNT_W'(1);
        if (retire_valid) begin
          if (ret_q != '1) ret_d = ret_q + CNT_W'(1);
          if (retire_pc == last_pc_q) begin
            same_d = same_inc;
            if (same_inc == SAME_LAST) halt = 1'b1;
          end else begin
            same_d    = '0;
            last_pc_d = retire_pc;
          end
          if (HALT_PC_EN && retire_pc == HALT_PC) halt = 1'b1;
        end
        // Halt has priority over an expiring budget on the same cycle.
        if (halt) state_d = S_DONE;
        else if (cyc_q == TMO_LAST) state_d = S_TIMEOUT;
      end
      default: ;
    endcase
    if (start && state_q != S_RST_HOLD) begin
      state_d   = S_RST_HOLD;
      rst_cnt_d = '0;
      same_d    = '0;
      cyc_d     = '0;
      ret_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if (AUTO_START) state_q <= S_RST_HOLD;
      else state_q <= S_IDLE;
      rst_cnt_q   <= '0;
      same_q      <= '0;
      last_pc_q   <= '1;
      cyc_q       <= '0;
      ret_q       <= '0;
      cpu_reset_q <= 1'b1;
      cpu_en_q    <= 1'b0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      same_q      <= same_d;
      last_pc_q   <= last_pc_d;
      cyc_q       <= cyc_d;
      ret_q       <= ret_d;
      cpu_reset_q <= (state_d == S_IDLE) || (state_d == S_RST_HOLD);
      cpu_en_q    <= (state_d == S_RUN);
      running_q   <= (state_d == S_RUN);
      done_q      <= (state_d == S_DONE);
      timeout_q   <= (state_d == S_TIMEOUT);
    end
  end

  assign cpu_reset    = cpu_reset_q;
  assign cpu_en       = cpu_en_q;
  assign running      = running_q;
  assign done         = done_q;
  assign timeout      = timeout_q;
  assign cycle_count  = cyc_q;
  assign retire_count = ret_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: a per-cycle vector table plus short
// sequences for timeout, restart, AUTO_START=0 and counter saturation.
module tb_cpu_run_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // A: HALT_PC_EN=0, MAX_CYCLES=20, auto start
  logic a_rst = 1'b1, a_st = 1'b0, a_rv = 1'b0;
  logic [31:0] a_pc = '0;
  logic a_cr, a_en, a_run, a_done, a_to;
  logic [31:0] a_cyc, a_ret;
  // B: HALT_PC_EN=1, AUTO_START=0
  logic b_rst = 1'b1, b_st = 1'b0, b_rv = 1'b0;
  logic [31:0] b_pc = '0;
  logic b_cr, b_en, b_run, b_done, b_to;
  logic [31:0] b_cyc, b_ret;
  // C: 5-bit counters, budget at the counter limit
  logic c_rst = 1'b1, c_st = 1'b0, c_rv = 1'b0;
  logic [31:0] c_pc = '0;
  logic c_cr, c_en, c_run, c_done, c_to;
  logic [4:0] c_cyc, c_ret;

  logic [4:0] fa, fb, fc;
  assign fa = {a_cr, a_en, a_run, a_done, a_to};
  assign fb = {b_cr, b_en, b_run, b_done, b_to};
  assign fc = {c_cr, c_en, c_run, c_done, c_to};

  cpu_run_ctrl #(.RESET_CYCLES(3), .MAX_CYCLES(20), .HALT_REPEAT(4),
    .HALT_PC(32'h0000_3ffc), .HALT_PC_EN(1'b0), .AUTO_START(1'b1), .CNT_W(32)) u_a (
    .clk(clk), .reset(a_rst), .start(a_st), .retire_valid(a_rv), .retire_pc(a_pc),
    .cpu_reset(a_cr), .cpu_en(a_en), .running(a_run), .done(a_done), .timeout(a_to),
    .cycle_count(a_cyc), .retire_count(a_ret));

  cpu_run_ctrl #(.RESET_CYCLES(3), .MAX_CYCLES(20), .HALT_REPEAT(4),
    .HALT_PC(32'h0000_3ffc), .HALT_PC_EN(1'b1), .AUTO_START(1'b0), .CNT_W(32)) u_b (
    .clk(clk), .reset(b_rst), .start(b_st), .retire_valid(b_rv), .retire_pc(b_pc),
    .cpu_reset(b_cr), .cpu_en(b_en), .running(b_run), .done(b_done), .timeout(b_to),
    .cycle_count(b_cyc), .retire_count(b_ret));

  cpu_run_ctrl #(.RESET_CYCLES(3), .MAX_CYCLES(32), .HALT_REPEAT(4),
    .HALT_PC(32'h0000_3ffc), .HALT_PC_EN(1'b0), .AUTO_START(1'b1), .CNT_W(5)) u_c (
    .clk(clk), .reset(c_rst), .start(c_st), .retire_valid(c_rv), .retire_pc(c_pc),
    .cpu_reset(c_cr), .cpu_en(c_en), .running(c_run), .done(c_done), .timeout(c_to),
    .cycle_count(c_cyc), .retire_count(c_ret));

  int unsigned n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  // One clock edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // flags = {cpu_reset, cpu_en, running, done, timeout}
  typedef struct {
    logic        rst, st, rv;
    logic [31:0] pc;
    logic [4:0]  flags;
    logic [31:0] cyc, ret;
  } vec_t;

  vec_t tbl[25];

  function automatic vec_t mk(logic rst, logic st, logic rv, logic [31:0] pc,
                              logic [4:0] flags, logic [31:0] cyc, logic [31:0] ret);
    vec_t v;
    v.rst = rst; v.st = st; v.rv = rv; v.pc = pc;
    v.flags = flags; v.cyc = cyc; v.ret = ret;
    return v;
  endfunction

  initial begin
    tbl[0]  = mk(1, 0, 0, 0,        5'b10000, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0,        5'b10000, 0, 0);
    tbl[2]  = mk(1, 0, 0, 0,        5'b10000, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0,        5'b10000, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0,        5'b10000, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0,        5'b01100, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0,        5'b01100, 1, 0);
    tbl[7]  = mk(0, 0, 1, 'h3000,   5'b01100, 2, 1);
    tbl[8]  = mk(0, 0, 1, 'h3004,   5'b01100, 3, 2);
    tbl[9]  = mk(0, 0, 1, 'h3008,   5'b01100, 4, 3);
    tbl[10] = mk(0, 0, 1, 'h300c,   5'b01100, 5, 4);
    tbl[11] = mk(0, 0, 0, 0,        5'b01100, 6, 4);
    tbl[12] = mk(0, 0, 1, 'h300c,   5'b01100, 7, 5);
    tbl[13] = mk(0, 0, 0, 0,        5'b01100, 8, 5);
    tbl[14] = mk(0, 0, 1, 'h300c,   5'b01100, 9, 6);
    tbl[15] = mk(0, 0, 1, 'h300c,   5'b00010, 10, 7);
    tbl[16] = mk(0, 0, 1, 'h3010,   5'b00010, 10, 7);
    tbl[17] = mk(0, 1, 0, 0,        5'b10000, 0, 0);
    tbl[18] = mk(0, 1, 0, 0,        5'b10000, 0, 0);
    tbl[19] = mk(0, 0, 0, 0,        5'b10000, 0, 0);
    tbl[20] = mk(0, 0, 0, 0,        5'b01100, 0, 0);
    tbl[21] = mk(0, 0, 1, 'h300c,   5'b01100, 1, 1);
    tbl[22] = mk(0, 0, 1, 'h300c,   5'b01100, 2, 2);
    tbl[23] = mk(0, 0, 1, 'h300c,   5'b01100, 3, 3);
    tbl[24] = mk(0, 0, 1, 'h300c,   5'b00010, 4, 4);

    #1;
    for (int i = 0; i < 25; i++) begin
      a_rst = tbl[i].rst; a_st = tbl[i].st; a_rv = tbl[i].rv; a_pc = tbl[i].pc;
      step();
      chk($sformatf("A row%0d flags", i), {27'b0, fa}, {27'b0, tbl[i].flags});
      chk($sformatf("A row%0d cycle", i), a_cyc, tbl[i].cyc);
      chk($sformatf("A row%0d retire", i), a_ret, tbl[i].ret);
    end
    a_st = 1'b0; a_rv = 1'b0;

    // Timeout after 20 RUN cycles, no halt
    a_st = 1'b1; step(); a_st = 1'b0;
    repeat (3) step();
    chk("A tmo run entry", {27'b0, fa}, 32'b01100);
    repeat (19) step();
    chk("A tmo pre flags", {27'b0, fa}, 32'b01100);
    chk("A tmo pre cycle", a_cyc, 19);
    step();
    chk("A tmo flags", {27'b0, fa}, 32'b00001);
    chk("A tmo cycle", a_cyc, 20);
    step();
    chk("A tmo sticky", {27'b0, fa}, 32'b00001);

    // Halt lands on the 20th RUN cycle: done wins over timeout
    a_st = 1'b1; step(); a_st = 1'b0;
    chk("A restart clears timeout", {27'b0, fa}, 32'b10000);
    repeat (3) step();
    repeat (16) step();
    a_rv = 1'b1; a_pc = 32'h4000;
    repeat (4) step();
    a_rv = 1'b0;
    chk("A halt@budget flags", {27'b0, fa}, 32'b00010);
    chk("A halt@budget cycle", a_cyc, 20);
    chk("A halt@budget retire", a_ret, 4);

    // B: AUTO_START=0, start ignored mid-hold, HALT_PC, restart, abort, reset
    step();
    chk("B reset flags", {27'b0, fb}, 32'b10000);
    b_rst = 1'b0;
    repeat (5) step();
    chk("B idle flags", {27'b0, fb}, 32'b10000);
    b_st = 1'b1; step(); b_st = 1'b0;
    chk("B hold0", {27'b0, fb}, 32'b10000);
    step();
    b_st = 1'b1; step(); b_st = 1'b0;
    chk("B hold2 start ignored", {27'b0, fb}, 32'b10000);
    step();
    chk("B run after 3", {27'b0, fb}, 32'b01100);
    b_rv = 1'b1; b_pc = 32'h0000_3ffc; step(); b_rv = 1'b0;
    chk("B halt_pc flags", {27'b0, fb}, 32'b00010);
    chk("B halt_pc cycle", b_cyc, 1);
    chk("B halt_pc retire", b_ret, 1);
    step();
    chk("B done sticky", {27'b0, fb}, 32'b00010);
    b_st = 1'b1; step(); b_st = 1'b0;
    chk("B restart flags", {27'b0, fb}, 32'b10000);
    chk("B restart cycle", b_cyc, 0);
    chk("B restart retire", b_ret, 0);
    repeat (2) step();
    chk("B restart hold", {27'b0, fb}, 32'b10000);
    step();
    chk("B restart run", {27'b0, fb}, 32'b01100);
    b_rv = 1'b1; b_pc = 32'h100; step(); b_rv = 1'b0;
    chk("B run retire", b_ret, 1);
    b_st = 1'b1; step(); b_st = 1'b0;
    chk("B abort flags", {27'b0, fb}, 32'b10000);
    chk("B abort cycle", b_cyc, 0);
    chk("B abort retire", b_ret, 0);
    repeat (3) step();
    chk("B abort rerun", {27'b0, fb}, 32'b01100);
    b_rv = 1'b1; b_pc = 32'h200; step();
    b_pc = 32'h204; step(); b_rv = 1'b0;
    chk("B pre-reset cycle", b_cyc, 2);
    b_rst = 1'b1; step(); b_rst = 1'b0;
    chk("B midrun reset flags", {27'b0, fb}, 32'b10000);
    chk("B midrun reset cycle", b_cyc, 0);
    chk("B midrun reset retire", b_ret, 0);
    repeat (4) step();
    chk("B back to idle", {27'b0, fb}, 32'b10000);

    // C: both counters saturate at 31 while the budget expires
    step(); c_rst = 1'b0;
    repeat (3) step();
    chk("C run entry", {27'b0, fc}, 32'b01100);
    c_rv = 1'b1;
    for (int i = 0; i < 31; i++) begin
      c_pc = 32'(i * 4); step();
    end
    chk("C pre flags", {27'b0, fc}, 32'b01100);
    chk("C pre cycle", {27'b0, c_cyc}, 31);
    chk("C pre retire", {27'b0, c_ret}, 31);
    c_pc = 32'h1000; step(); c_rv = 1'b0;
    chk("C sat flags", {27'b0, fc}, 32'b00001);
    chk("C sat cycle", {27'b0, c_cyc}, 31);
    chk("C sat retire", {27'b0, c_ret}, 31);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
